// File: rtl/piso_pkg.sv
// piso_pkg: shared serializer constants for the piso block.
package piso_pkg;
    localparam int SERIAL_WIDTH = 4;
endpackage

// File: rtl/piso.sv
// piso: parallel-in/serial-out shift register; load wins over shift, DOUT taps the register directly.
module piso
    import piso_pkg::*;
#(
    parameter int   WIDTH     = SERIAL_WIDTH,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic FILL      = 1'b0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] DIN,
    output logic             DOUT
);
    logic [WIDTH-1:0] sreg_q, sreg_d;

    always_comb begin
        sreg_d = LOAD      ? DIN :
                 MSB_FIRST ? {sreg_q[WIDTH-2:0], FILL} :
                             {FILL, sreg_q[WIDTH-1:1]};
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) sreg_q <= '0;
        else     sreg_q <= sreg_d;
    end

    assign DOUT = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
endmodule

// File: tb/tb_piso.sv
// tb_piso: directed self-checking bench for piso (default 4-bit MSB-first and 8-bit LSB-first FILL=1).
module tb_piso;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load = 1'b0;
    logic [3:0] din = '0;
    logic       dout;
    logic       load8 = 1'b0;
    logic [7:0] din8 = '0;
    logic       dout8;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    piso dut (.CLK(clk), .RST(rst), .LOAD(load), .DIN(din), .DOUT(dout));

    piso #(.WIDTH(8), .MSB_FIRST(1'b0), .FILL(1'b1)) dut8 (
        .CLK(clk), .RST(rst), .LOAD(load8), .DIN(din8), .DOUT(dout8)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst = 1'b1;
        load = 1'b0;
        load8 = 1'b0;
        #1;
        checks++;
        if (dout !== 1'b0) begin errors++; $display("FAIL reset_async dout=%b exp=0", dout); end
        checks++;
        if (dout8 !== 1'b0) begin errors++; $display("FAIL reset_async8 dout=%b exp=0", dout8); end
        tick();
        checks++;
        if (dout !== 1'b0) begin errors++; $display("FAIL reset_held dout=%b exp=0", dout); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (dout !== 1'b0) begin errors++; $display("FAIL reset_release%0d dout=%b exp=0", i, dout); end
        end
    endtask

    task automatic test_word(input logic [3:0] w, input string name);
        @(negedge clk);
        load = 1'b1;
        din = w;
        tick();
        checks++;
        if (dout !== w[3]) begin errors++; $display("FAIL %s bit0 dout=%b exp=%b", name, dout, w[3]); end
        @(negedge clk);
        load = 1'b0;
        din = ~w;
        for (int k = 1; k < 4; k++) begin
            tick();
            checks++;
            if (dout !== w[3-k]) begin errors++; $display("FAIL %s bit%0d dout=%b exp=%b", name, k, dout, w[3-k]); end
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (dout !== 1'b0) begin errors++; $display("FAIL %s fill%0d dout=%b exp=0", name, k, dout); end
        end
    endtask

    task automatic test_load_shift;
        test_word(4'b1011, "word1011");
    endtask

    task automatic test_second_word;
        test_word(4'b1100, "word1100");
    endtask

    task automatic test_interrupt;
        logic [3:0] exp;
        exp = 4'b0110;
        @(negedge clk);
        load = 1'b1;
        din = 4'b1011;
        tick();
        checks++;
        if (dout !== 1'b1) begin errors++; $display("FAIL intr_first dout=%b exp=1", dout); end
        @(negedge clk);
        load = 1'b0;
        tick();
        checks++;
        if (dout !== 1'b0) begin errors++; $display("FAIL intr_shift dout=%b exp=0", dout); end
        @(negedge clk);
        load = 1'b1;
        din = 4'b0110;
        tick();
        checks++;
        if (dout !== exp[3]) begin errors++; $display("FAIL intr_reload dout=%b exp=%b", dout, exp[3]); end
        @(negedge clk);
        load = 1'b0;
        for (int k = 1; k < 4; k++) begin
            tick();
            checks++;
            if (dout !== exp[3-k]) begin errors++; $display("FAIL intr_bit%0d dout=%b exp=%b", k, dout, exp[3-k]); end
        end
        tick();
        checks++;
        if (dout !== 1'b0) begin errors++; $display("FAIL intr_drained dout=%b exp=0", dout); end
    endtask

    task automatic test_hold_load;
        @(negedge clk);
        load = 1'b1;
        din = 4'b1011;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (dout !== 1'b1) begin errors++; $display("FAIL hold_load%0d dout=%b exp=1", i, dout); end
        end
        @(negedge clk);
        din = 4'b0110;
        tick();
        checks++;
        if (dout !== 1'b0) begin errors++; $display("FAIL hold_newdin dout=%b exp=0", dout); end
        @(negedge clk);
        load = 1'b0;
        tick();
        checks++;
        if (dout !== 1'b1) begin errors++; $display("FAIL hold_shift dout=%b exp=1", dout); end
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        load = 1'b1;
        din = 4'b1111;
        tick();
        checks++;
        if (dout !== 1'b1) begin errors++; $display("FAIL areset_loaded dout=%b exp=1", dout); end
        @(negedge clk);
        load = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (dout !== 1'b0) begin errors++; $display("FAIL areset_midword dout=%b exp=0", dout); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (dout !== 1'b0) begin errors++; $display("FAIL areset_after%0d dout=%b exp=0", i, dout); end
        end
    endtask

    task automatic test_reset_over_load;
        @(negedge clk);
        rst = 1'b1;
        load = 1'b1;
        din = 4'b1111;
        tick();
        checks++;
        if (dout !== 1'b0) begin errors++; $display("FAIL rst_priority dout=%b exp=0", dout); end
        @(negedge clk);
        rst = 1'b0;
        load = 1'b0;
        tick();
        checks++;
        if (dout !== 1'b0) begin errors++; $display("FAIL rst_priority_after dout=%b exp=0", dout); end
    endtask

    task automatic test_variant;
        logic [7:0] w;
        w = 8'hA5;
        @(negedge clk);
        load8 = 1'b1;
        din8 = w;
        tick();
        checks++;
        if (dout8 !== w[0]) begin errors++; $display("FAIL var_bit0 dout=%b exp=%b", dout8, w[0]); end
        @(negedge clk);
        load8 = 1'b0;
        din8 = 8'h00;
        for (int k = 1; k < 8; k++) begin
            tick();
            checks++;
            if (dout8 !== w[k]) begin errors++; $display("FAIL var_bit%0d dout=%b exp=%b", k, dout8, w[k]); end
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (dout8 !== 1'b1) begin errors++; $display("FAIL var_fill%0d dout=%b exp=1", k, dout8); end
        end
    endtask

    initial begin
        test_reset();
        test_load_shift();
        test_second_word();
        test_interrupt();
        test_hold_load();
        test_async_reset();
        test_reset_over_load();
        test_variant();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
